// File: rtl/cmp_serial_nbit.sv
// Multi-cycle magnitude comparator. It captures two WIDTH-bit operands
// and compares them CHUNK bits per cycle, starting with the MSB chunk.
// Signed operands are mapped to offset binary at capture time. After
// that, every chunk compare is unsigned.
module cmp_serial_nbit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_err
        $error("cmp_serial_nbit: need WIDTH >= 2, CHUNK >= 1 and CHUNK dividing WIDTH");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             dir_gt_q, dir_gt_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

    logic [WIDTH-1:0] sign_flip;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic             last_chunk;
    logic             dec_now, gt_now;

    // Select the current chunk and fold it into the running decision
    always_comb begin
        sign_flip            = '0;
        sign_flip[WIDTH-1]   = signed_mode;
        a_chunk              = a_q[int'(cnt_q) * CHUNK +: CHUNK];
        b_chunk              = b_q[int'(cnt_q) * CHUNK +: CHUNK];
        last_chunk           = (cnt_q == '0);
        // The first differing chunk (MSB first) fixes the direction
        dec_now              = decided_q | (a_chunk != b_chunk);
        gt_now               = decided_q ? dir_gt_q : (a_chunk > b_chunk);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a low enable always forces the FSM back to IDLE
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (last_chunk) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: operand capture, chunk walk, result update
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        dir_gt_d  = dir_gt_q;
        done_d    = 1'b0;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        if (!enable) begin
            eq_d = 1'b0;
            gt_d = 1'b0;
            lt_d = 1'b0;
        end else if (state_q == IDLE) begin
            if (start) begin
                a_d       = a ^ sign_flip;
                b_d       = b ^ sign_flip;
                cnt_d     = CW'(NCHUNK - 1);
                decided_d = 1'b0;
                dir_gt_d  = 1'b0;
            end
        end else begin
            if (last_chunk) begin
                done_d = 1'b1;
                eq_d   = ~dec_now;
                gt_d   = dec_now & gt_now;
                lt_d   = dec_now & ~gt_now;
            end else begin
                cnt_d     = cnt_q - CW'(1);
                decided_d = dec_now;
                dir_gt_d  = gt_now;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            dir_gt_q  <= 1'b0;
            done_q    <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            dir_gt_q  <= dir_gt_d;
            done_q    <= done_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
        end
    end

    // Output decode
    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        eq   = eq_q;
        gt   = gt_q;
        lt   = lt_q;
    end

endmodule

// File: tb/tb_cmp_serial_nbit.sv
// Directed bench for cmp_serial_nbit. It uses a 16/4 instance for the
// table and the corner sequences, and an 8/8 instance for single-cycle mode.
module tb_cmp_serial_nbit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, eq, gt, lt;

    logic        start8 = 1'b0;
    logic        sm8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, eq8, gt8, lt8;

    int n_cmp = 0;
    int n_fail = 0;

    cmp_serial_nbit #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
        .signed_mode(signed_mode), .a(a), .b(b),
        .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
    );

    cmp_serial_nbit #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .start(start8),
        .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [2:0]  exp;  // {eq, gt, lt}
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{16'h8000, 16'h7FFF, 1'b0, 3'b010};
        vecs[1]  = '{16'h8000, 16'h7FFF, 1'b1, 3'b001};
        vecs[2]  = '{16'hFFFF, 16'h0001, 1'b1, 3'b001};
        vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, 3'b010};
        vecs[4]  = '{16'h1234, 16'h1234, 1'b0, 3'b100};
        vecs[5]  = '{16'h1234, 16'h1234, 1'b1, 3'b100};
        vecs[6]  = '{16'h00F0, 16'h00E0, 1'b0, 3'b010};
        vecs[7]  = '{16'h1000, 16'h0FFF, 1'b0, 3'b010};
        vecs[8]  = '{16'h0001, 16'h0002, 1'b0, 3'b001};
        vecs[9]  = '{16'h8001, 16'h8002, 1'b1, 3'b001};
        vecs[10] = '{16'h7FFF, 16'h8000, 1'b1, 3'b010};

        // Reset state
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", {eq, gt, lt}, 0);
        check("rst_res8", {busy8, done8, eq8, gt8, lt8}, 0);
        rst_n = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        check("idle_res", {busy, done, eq, gt, lt}, 0);

        // Table: latency, busy window, result, done pulse, hold
        for (int i = 0; i < 11; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            signed_mode = vecs[i].sm;
            start = 1'b1;
            tick();                         // edge 0
            start = 1'b0;
            a = ~vecs[i].a;                 // changes during RUN must not matter
            b = ~vecs[i].b;
            signed_mode = ~vecs[i].sm;
            check($sformatf("v%0d_busy0", i), {busy, done}, 2'b10);
            for (int k = 1; k < 4; k++) begin
                tick();
                check($sformatf("v%0d_busy%0d", i, k), {busy, done}, 2'b10);
            end
            tick();                         // edge 4
            check($sformatf("v%0d_done", i), {busy, done}, 2'b01);
            check($sformatf("v%0d_res", i), {eq, gt, lt}, vecs[i].exp);
            tick();
            check($sformatf("v%0d_pulse", i), done, 0);
            check($sformatf("v%0d_hold", i), {eq, gt, lt}, vecs[i].exp);
        end

        // Back-to-back: start in the done cycle
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("b2b_first_done", done, 1);
        check("b2b_first_res", {eq, gt, lt}, 3'b100);
        a = 16'h1235; b = 16'h1234; start = 1'b1;
        tick();                             // edge 5 accepts
        start = 1'b0;
        check("b2b_busy", {busy, done}, 2'b10);
        check("b2b_eq_held5", {eq, gt, lt}, 3'b100);
        tick();
        tick();
        tick();
        check("b2b_eq_held7", {eq, gt, lt, done}, 4'b1000);
        tick();                             // edge 9
        check("b2b_second_done", done, 1);
        check("b2b_second_res", {eq, gt, lt}, 3'b010);

        // Start while busy is ignored
        tick();
        a = 16'h0001; b = 16'h0002; start = 1'b1;
        tick();                             // edge 0
        start = 1'b0;
        tick();                             // edge 1
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        tick();                             // edge 2
        start = 1'b0;
        check("ign_busy2", {busy, done}, 2'b10);
        tick();
        tick();                             // edge 4
        check("ign_done", done, 1);
        check("ign_res", {eq, gt, lt}, 3'b001);
        begin
            int extra = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (done || busy) extra++;
            end
            check("ign_no_extra", extra, 0);
        end

        // Enable drop mid-RUN aborts and clears the results
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        tick();                             // edge 0
        start = 1'b0;
        tick();                             // edge 1
        enable = 1'b0;
        tick();                             // edge 2
        check("en_abort", {busy, done, eq, gt, lt}, 0);
        start = 1'b1;                       // ignored while disabled
        begin
            int seen = 0;
            for (int k = 0; k < 5; k++) begin
                tick();
                if (busy || done || eq || gt || lt) seen++;
            end
            check("en_off_quiet", seen, 0);
        end
        start = 1'b0;
        enable = 1'b1;
        a = 16'h0000; b = 16'h0000; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("en_pre_res", {done, eq, gt, lt}, 0);
        tick();
        check("en_res", {done, eq, gt, lt}, 4'b1100);

        // Asynchronous reset mid-RUN
        tick();
        a = 16'h0001; b = 16'h0002; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst_now", {busy, done, eq, gt, lt}, 0);
        #2 rst_n = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (busy || done || eq || gt || lt) seen++;
            end
            check("arst_no_done", seen, 0);
        end

        // Single-chunk instance: done one cycle after start
        a8 = 8'h7F; b8 = 8'h80; sm8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("w8_busy", {busy8, done8}, 2'b10);
        tick();
        check("w8_done", {busy8, done8}, 2'b01);
        check("w8_res_u", {eq8, gt8, lt8}, 3'b001);
        sm8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("w8_pulse", done8, 0);
        check("w8_hold", {eq8, gt8, lt8}, 3'b001);
        tick();
        check("w8_res_s", {done8, eq8, gt8, lt8}, 4'b1010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
